// File: rtl/lsu_btn_sw_in.sv
// rtl/lsu_btn_sw_in.sv - memory-mapped slide switch and debounced push button input peripheral
module lsu_btn_sw_in #(
  parameter int unsigned DB_CYCLES = 500000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        st_en,
  input  logic [2:0]  datamode,
  input  logic [3:0]  addr,
  input  logic [31:0] data_in,
  input  logic [17:0] sw_i,
  input  logic [3:0]  btn_ni,
  output logic [31:0] data_o,
  output logic        irq_o
);

  localparam int unsigned CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  localparam logic [1:0] REG_SW   = 2'd0;
  localparam logic [1:0] REG_BTN  = 2'd1;
  localparam logic [1:0] REG_EDGE = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  logic [17:0]   sw_q1, sw_q2;
  logic [3:0]    btn_q1, btn_q2;
  logic [3:0]    btn_s;
  logic [3:0]    btn_db;
  logic [3:0]    btn_edge;
  logic [3:0]    btn_mask;
  logic [CW-1:0] cnt [4];

  logic [3:0]    db_load;
  logic [3:0]    press;
  logic [3:0]    lane_we;
  logic [3:0]    edge_clr;
  logic          mask_we;
  logic [31:0]   rd_word;
  logic [15:0]   rd_half;
  logic [7:0]    rd_byte;
  logic          sext;

  // Two-flop synchronizers; buttons idle high (released) out of reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sw_q1  <= '0;
      sw_q2  <= '0;
      btn_q1 <= '1;
      btn_q2 <= '1;
    end else begin
      sw_q1  <= sw_i;
      sw_q2  <= sw_q1;
      btn_q1 <= btn_ni;
      btn_q2 <= btn_q1;
    end
  end

  assign btn_s = ~btn_q2;

  always_comb begin
    db_load = '0;
    press   = '0;
    for (int i = 0; i < 4; i++) begin
      db_load[i] = (btn_s[i] != btn_db[i]) && (cnt[i] == CNT_MAX);
      press[i]   = db_load[i] && btn_s[i];
    end
  end

  // Count stays at 0 while the synchronized level matches the accepted one,
  // so any bounce back restarts the qualification window.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      btn_db <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (btn_s[i] == btn_db[i]) begin
          cnt[i] <= '0;
        end else if (db_load[i]) begin
          cnt[i]    <= '0;
          btn_db[i] <= btn_s[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    lane_we = 4'b0000;
    case (datamode[1:0])
      2'd0:    lane_we = 4'b0001 << addr[1:0];
      2'd1:    lane_we = addr[1] ? 4'b1100 : 4'b0011;
      default: lane_we = 4'b1111;
    endcase
    if (!st_en) begin
      lane_we = 4'b0000;
    end
  end

  assign edge_clr = (addr[3:2] == REG_EDGE && lane_we[0]) ? data_in[3:0] : 4'b0000;
  assign mask_we  = (addr[3:2] == REG_CTRL) && lane_we[0];

  // A press on the same edge as a write-1-to-clear keeps the flag set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      btn_edge <= '0;
      btn_mask <= '0;
    end else begin
      btn_edge <= (btn_edge & ~edge_clr) | press;
      if (mask_we) begin
        btn_mask <= data_in[3:0];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    case (addr[3:2])
      REG_SW:   rd_word = {14'b0, sw_q2};
      REG_BTN:  rd_word = {28'b0, btn_db};
      REG_EDGE: rd_word = {28'b0, btn_edge};
      REG_CTRL: rd_word = {28'b0, btn_mask};
      default:  rd_word = '0;
    endcase
  end

  always_comb begin
    rd_half = addr[1] ? rd_word[31:16] : rd_word[15:0];
    rd_byte = rd_word[7:0];
    case (addr[1:0])
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
  end

  assign sext = ~datamode[2];

  always_comb begin
    data_o = rd_word;
    case (datamode[1:0])
      2'd0:    data_o = {{24{sext & rd_byte[7]}}, rd_byte};
      2'd1:    data_o = {{16{sext & rd_half[15]}}, rd_half};
      default: data_o = rd_word;
    endcase
  end

  assign irq_o = |(btn_edge & btn_mask);

endmodule

// File: tb/tb_lsu_btn_sw_in.sv
// tb/tb_lsu_btn_sw_in.sv - directed scoreboard bench for lsu_btn_sw_in with DB_CYCLES=4
module tb_lsu_btn_sw_in;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        st_en;
  logic [2:0]  datamode;
  logic [3:0]  addr;
  logic [31:0] data_in;
  logic [17:0] sw_i;
  logic [3:0]  btn_ni;
  logic [31:0] data_o;
  logic        irq_o;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] exp_q[$];

  always #50 clk_i = ~clk_i;

  lsu_btn_sw_in #(.DB_CYCLES(4)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .st_en    (st_en),
    .datamode (datamode),
    .addr     (addr),
    .data_in  (data_in),
    .sw_i     (sw_i),
    .btn_ni   (btn_ni),
    .data_o   (data_o),
    .irq_o    (irq_o)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    n_total++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s: observed %h, no expected value queued", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [2:0] m,
                    input logic [31:0] exp);
    exp_q.push_back(exp);
    st_en    = 1'b0;
    addr     = a;
    datamode = m;
    #1;
    check(tag, data_o);
  endtask

  task automatic irq_chk(input string tag, input logic exp);
    exp_q.push_back({31'b0, exp});
    #1;
    check(tag, {31'b0, irq_o});
  endtask

  task automatic st(input logic [3:0] a, input logic [2:0] m, input logic [31:0] d);
    st_en    = 1'b1;
    addr     = a;
    datamode = m;
    data_in  = d;
    tick();
    st_en    = 1'b0;
  endtask

  initial begin
    rst_i    = 1'b1;
    st_en    = 1'b0;
    datamode = 3'd2;
    addr     = 4'h0;
    data_in  = '0;
    sw_i     = '0;
    btn_ni   = 4'hF;
    tick(2);
    rst_i = 1'b0;

    rd("rst_sw", 4'h0, 3'd2, 32'h0);
    rd("rst_btn", 4'h4, 3'd2, 32'h0);
    rd("rst_edge", 4'h8, 3'd2, 32'h0);
    rd("rst_ctrl", 4'hC, 3'd2, 32'h0);
    irq_chk("rst_irq", 1'b0);

    // press btn 0: accepted on the 6th edge
    btn_ni[0] = 1'b0;
    tick(5);
    rd("press_early", 4'h4, 3'd2, 32'h0);
    tick(1);
    rd("press_state", 4'h4, 3'd2, 32'h1);
    rd("press_edge", 4'h8, 3'd2, 32'h1);
    irq_chk("press_irq_masked", 1'b0);
    rd("edge_no_rd_clear", 4'h8, 3'd2, 32'h1);

    st(4'h8, 3'd2, 32'h1);
    rd("w1c_edge", 4'h8, 3'd2, 32'h0);
    btn_ni[0] = 1'b1;
    tick(8);
    rd("release_state", 4'h4, 3'd2, 32'h0);
    rd("release_edge", 4'h8, 3'd2, 32'h0);

    // 3-cycle bounce on btn 1 must be rejected
    btn_ni[1] = 1'b0;
    tick(3);
    btn_ni[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      rd("bounce_state", 4'h4, 3'd2, 32'h0);
      rd("bounce_edge", 4'h8, 3'd2, 32'h0);
    end

    st(4'hC, 3'd2, 32'h1);
    rd("ctrl_mask", 4'hC, 3'd2, 32'h1);
    irq_chk("irq_idle", 1'b0);
    btn_ni[0] = 1'b0;
    tick(6);
    irq_chk("irq_set", 1'b1);
    rd("irq_edge", 4'h8, 3'd2, 32'h1);
    st(4'h9, 3'd0, 32'hFF);
    rd("byte9_keep_edge", 4'h8, 3'd2, 32'h1);
    irq_chk("byte9_keep_irq", 1'b1);
    st(4'h8, 3'd2, 32'h1);
    rd("clr_edge", 4'h8, 3'd2, 32'h0);
    irq_chk("clr_irq", 1'b0);
    st(4'h9, 3'd0, 32'hFF);
    rd("byte9_noop", 4'h8, 3'd2, 32'h0);
    rd("byte9_state", 4'h4, 3'd2, 32'h1);
    st(4'hD, 3'd0, 32'h0);
    rd("ctrl_lane1_noop", 4'hC, 3'd2, 32'h1);
    st(4'h4, 3'd2, 32'hF);
    rd("btn_state_ro", 4'h4, 3'd2, 32'h1);
    st(4'h0, 3'd2, 32'hFFFF);
    rd("sw_state_ro", 4'h0, 3'd2, 32'h0);

    // switches: two-flop delay and load extension
    sw_i = 18'h30081;
    tick(1);
    rd("sw_sync1", 4'h0, 3'd2, 32'h0);
    tick(1);
    rd("sw_word", 4'h0, 3'd2, 32'h00030081);
    rd("sw_byte_sext", 4'h0, 3'd0, 32'hFFFFFF81);
    rd("sw_byte_zext", 4'h0, 3'd4, 32'h00000081);
    rd("sw_half_hi", 4'h2, 3'd1, 32'h00000003);
    rd("sw_byte2", 4'h2, 3'd0, 32'h00000003);
    rd("sw_half_lo", 4'h0, 3'd1, 32'h00000081);
    rd("sw_byte1", 4'h1, 3'd4, 32'h00000000);

    // btn 2 press collides with a W1C of bit 2; btn 0 releases meanwhile
    btn_ni[0] = 1'b1;
    btn_ni[2] = 1'b0;
    tick(5);
    st_en    = 1'b1;
    addr     = 4'h8;
    datamode = 3'd2;
    data_in  = 32'h4;
    tick(1);
    st_en = 1'b0;
    rd("collide_edge", 4'h8, 3'd2, 32'h4);
    rd("collide_state", 4'h4, 3'd2, 32'h4);
    irq_chk("collide_irq", 1'b0);
    st(4'hC, 3'd0, 32'h4);
    irq_chk("mask4_irq", 1'b1);
    st(4'hA, 3'd0, 32'h4);
    rd("byteA_noop", 4'h8, 3'd2, 32'h4);
    st(4'h9, 3'd1, 32'h4);
    rd("half9_clear", 4'h8, 3'd2, 32'h0);
    irq_chk("half9_irq", 1'b0);

    sw_i = 18'h18000;
    tick(2);
    rd("sw2_word", 4'h0, 3'd2, 32'h00018000);
    rd("sw2_half_sext", 4'h0, 3'd1, 32'hFFFF8000);
    rd("sw2_half_zext", 4'h0, 3'd5, 32'h00008000);
    rd("sw2_half_hi", 4'h2, 3'd1, 32'h00000001);
    rd("sw2_byte1_sext", 4'h1, 3'd0, 32'hFFFFFF80);

    // reset in the middle of btn 3's debounce count
    btn_ni[3] = 1'b0;
    tick(4);
    rst_i  = 1'b1;
    btn_ni = 4'hF;
    tick(1);
    rst_i = 1'b0;
    rd("rst2_sw", 4'h0, 3'd2, 32'h0);
    rd("rst2_btn", 4'h4, 3'd2, 32'h0);
    rd("rst2_edge", 4'h8, 3'd2, 32'h0);
    rd("rst2_ctrl", 4'hC, 3'd2, 32'h0);
    irq_chk("rst2_irq", 1'b0);
    tick(10);
    rd("abandon_state", 4'h4, 3'd2, 32'h0);
    rd("abandon_edge", 4'h8, 3'd2, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lsu_btn_sw_in.md
LSU_BTN_SW_IN -- requirements
Module: lsu_btn_sw_in

Interface
REQ-001 Parameter: DB_CYCLES, default 500000, number of consecutive stable cycles required to accept a debounced button change (minimum 2).
REQ-002 Port: clk_i  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst_i  input  1  reset, synchronous and active-high.
REQ-004 Port: st_en  input  1  store enable from the LSU.
REQ-005 Port: datamode  input  3  [1:0] access size (0 byte, 1 half-word, 2 or 3 word); [2] load extension (0 sign-extend, 1 zero-extend).
REQ-006 Port: addr  input  4  byte address within the 16-byte peripheral window.
REQ-007 Port: data_in  input  32  store data, LSB-aligned.
REQ-008 Port: sw_i  input  18  raw asynchronous slide switches, 1 = on.
REQ-009 Port: btn_ni  input  4  raw asynchronous push buttons, active-low (0 = pressed).
REQ-010 Port: data_o  output  32  combinational load data for the current addr/datamode.
REQ-011 Port: irq_o  output  1  level interrupt, high while any enabled press flag is set.

Function
REQ-012 Register map (word index addr[3:2]): 0 SW_STATE = {14'b0, sw_s}; 1 BTN_STATE = {28'b0, btn_db}; 2 BTN_EDGE = {28'b0, edge}; 3 CTRL = {28'b0, mask}.
REQ-013 Each sw_i and btn_ni bit SHALL pass a 2-flop synchronizer; sw_s is the second-stage output, with no debounce.
REQ-014 Per button i, with s = NOT(second-stage btn_ni[i]): when s == btn_db[i], the counter SHALL clear to 0; otherwise it SHALL increment by 1.
REQ-015 When s != btn_db[i] and the counter == DB_CYCLES-1, btn_db[i] SHALL load s and the counter SHALL clear, on that same edge.
REQ-016 Debounce latency: for a raw input held stable, btn_db changes exactly DB_CYCLES+2 rising edges after the first sampling edge of the new raw level.
REQ-017 Any return of s to btn_db[i] before the count completes SHALL restart the count from 0, so bounces shorter than DB_CYCLES cycles are rejected.
REQ-018 On the edge where btn_db[i] goes 0->1 (press), edge[i] SHALL set to 1. Release (1->0) SHALL NOT affect edge.
REQ-019 Store byte lanes written: byte -> lane addr[1:0]; half -> lanes {addr[1],0} and {addr[1],1}; word -> all four lanes. addr[0] is ignored for half-word; addr[1:0] are ignored for word.
REQ-020 A store writing lane 0 of BTN_EDGE SHALL clear every edge[i] for which data_in[i] == 1 (write-1-to-clear).
REQ-021 A store writing lane 0 of CTRL SHALL load mask <= data_in[3:0].
REQ-022 All other store lanes and registers (SW_STATE, BTN_STATE, upper lanes) SHALL be ignored with no side effect.
REQ-023 If a press sets edge[i] in the same cycle that a W1C store clears edge[i], set SHALL win and edge[i] SHALL be 1.
REQ-024 Load, word access: data_o = the full selected register.
REQ-025 Load, half-word access: the selected half (addr[1]) SHALL be extended to 32 bits per datamode[2].
REQ-026 Load, byte access: the selected lane SHALL be extended to 32 bits per datamode[2].
REQ-027 Loads SHALL have no side effects; reading BTN_EDGE does not clear it.
REQ-028 irq_o SHALL equal |(edge & mask), derived combinationally from registered state.

Reset
REQ-029 While rst_i is high at a rising edge, the following SHALL clear to 0: all debounce counters, btn_db, edge, mask, and the switch synchronizer flops.
REQ-030 Under the same reset condition, the button synchronizer flops SHALL load 1 (released).
REQ-031 After reset, data_o SHALL read 0 for every address and irq_o SHALL be 0.
REQ-032 Reset asserted mid-debounce SHALL abandon the count; no btn_db change or edge set occurs from the interrupted count.

Verification (DB_CYCLES=4)
REQ-033 Reset: rst_i high 1 cycle -> word loads at 0x0, 0x4, 0x8, 0xC all return 0x00000000, and irq_o = 0.
REQ-034 Press: btn_ni[0] 1->0 held -> BTN_STATE reads 0x1 exactly 6 edges later, BTN_EDGE reads 0x1 on the same cycle, and irq_o stays 0 (mask 0).
REQ-035 Bounce: btn_ni[1] low 3 cycles then high -> BTN_STATE and BTN_EDGE remain 0x0 for 20 cycles.
REQ-036 IRQ and clear: word store 0x1 to 0xC, then press btn 0 -> irq_o = 1; word store 0x1 to 0x8 -> edge = 0 and irq_o = 0 next cycle; byte store to 0x9 -> no change.
REQ-037 Extension: sw_i = 18'h30081, wait 2 cycles -> word load 0x0 = 0x00030081; datamode 0 at addr 0 -> 0xFFFFFF81; datamode 4 -> 0x00000081; datamode 1 at addr 2 -> 0x00000003.
REQ-038 Collision: a W1C store to 0x8 with data 0x4 on the same edge as btn 2's press sets edge[2] -> BTN_EDGE reads 0x4.
